// File: rtl/mux_select_arbiter.sv
// Two-requester arbiter feeding one registered output word over a valid/ready handshake.
// Sticky round-robin: the last winner keeps the path until MAX_BURST grants, then yields.
module mux_select_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_0,
  input  logic [DATA_WIDTH-1:0] data_0,
  output logic                  ack_0,
  input  logic                  req_1,
  input  logic [DATA_WIDTH-1:0] data_1,
  output logic                  ack_1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  select
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_burst_cnt;
  logic                  r_last_grant;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_select;
  logic                  r_ack_0;
  logic                  r_ack_1;

  logic          w_accept;
  logic          w_any;
  logic          w_both;
  logic          w_sticky;
  logic          w_grant;
  logic [CW-1:0] w_next_cnt;

  assign w_accept = (r_state == IDLE) || out_ready;
  assign w_any    = req_0 | req_1;
  assign w_both   = req_0 & req_1;
  // A zero count means no burst is in progress, so the previous winner is not favoured.
  assign w_sticky = (r_burst_cnt != '0) && (r_burst_cnt < MAX_CNT);
  assign w_grant  = w_both ? (w_sticky ? r_last_grant : ~r_last_grant) : req_1;

  always_comb begin
    w_next_cnt = ONE_CNT;
    if ((w_grant == r_last_grant) && (r_burst_cnt != '0)) begin
      w_next_cnt = (r_burst_cnt == MAX_CNT) ? MAX_CNT : r_burst_cnt + ONE_CNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_burst_cnt  <= '0;
      r_last_grant <= 1'b1;
      r_out_data   <= '0;
      r_select     <= 1'b0;
      r_ack_0      <= 1'b0;
      r_ack_1      <= 1'b0;
    end else begin
      r_ack_0 <= 1'b0;
      r_ack_1 <= 1'b0;
      if (w_accept) begin
        if (w_any) begin
          r_state      <= HOLD;
          r_out_data   <= w_grant ? data_1 : data_0;
          r_select     <= w_grant;
          r_ack_0      <= ~w_grant;
          r_ack_1      <= w_grant;
          r_burst_cnt  <= w_next_cnt;
          r_last_grant <= w_grant;
        end else begin
          r_state <= IDLE;
          if (r_state == IDLE) begin
            r_burst_cnt <= '0;
          end
        end
      end
    end
  end

  assign out_valid = (r_state == HOLD);
  assign out_data  = r_out_data;
  assign select    = r_select;
  assign ack_0     = r_ack_0;
  assign ack_1     = r_ack_1;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter: each task drives a scenario and checks hand-computed results.
module tb_mux_select_arbiter;

  logic        clk;
  logic        rst;
  logic        req_0;
  logic [31:0] data_0;
  logic        ack_0;
  logic        req_1;
  logic [31:0] data_1;
  logic        ack_1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        select;

  int errors = 0;
  int checks = 0;

  mux_select_arbiter #(.DATA_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .data_0(data_0), .ack_0(ack_0),
    .req_1(req_1), .data_1(data_1), .ack_1(ack_1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .select(select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic [31:0] d0,
                               input logic r1, input logic [31:0] d1, input logic rdy);
    req_0 = r0; data_0 = d0; req_1 = r1; data_1 = d1; out_ready = rdy;
  endtask

  task automatic do_reset();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, select, ack_1, ack_0} !== 4'b0000 || out_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b sel=%b ack1=%b ack0=%b data=%h, want all 0",
               out_valid, select, ack_1, ack_0, out_data);
    end
  endtask

  task automatic test_single();
    applyStimulus(1'b1, 32'hAAAA_AAAA, 1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hAAAA_AAAA || select !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_grant: valid=%b data=%h sel=%b, want 1 aaaaaaaa 0",
               out_valid, out_data, select);
    end
    checks++;
    if ({ack_1, ack_0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL single_ack: acks=%b, want 01", {ack_1, ack_0});
    end
    req_0 = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || {ack_1, ack_0} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_drop: valid=%b acks=%b, want 0 00", out_valid, {ack_1, ack_0});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    applyStimulus(1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0 || select !== 1'b0 || {ack_1, ack_0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL simultaneous_first: valid=%b data=%h sel=%b acks=%b, want 1 00000000 0 01",
               out_valid, out_data, select, {ack_1, ack_0});
    end
  endtask

  task automatic test_burst_cap();
    logic        exp_sel;
    logic [31:0] exp_data;
    do_reset();
    applyStimulus(1'b1, 32'h1000_0000, 1'b1, 32'h2000_0000, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_sel  = ((i / 4) % 2) == 1;
      exp_data = exp_sel ? 32'h2000_0000 : 32'h1000_0000;
      checks++;
      if (select !== exp_sel || out_data !== exp_data || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL burst_word%0d: sel=%b data=%h valid=%b, want %b %h 1",
                 i, select, out_data, out_valid, exp_sel, exp_data);
      end
      checks++;
      if ({ack_1, ack_0} !== {exp_sel, ~exp_sel}) begin
        errors++;
        $display("[TB] FAIL burst_ack%0d: acks=%b, want %b", i, {ack_1, ack_0}, {exp_sel, ~exp_sel});
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    applyStimulus(1'b1, 32'h0000_0011, 1'b0, 32'h0000_0022, 1'b1);
    repeat (6) tick();
    req_1 = 1'b1;
    tick();
    checks++;
    if (select !== 1'b1 || out_data !== 32'h0000_0022) begin
      errors++;
      $display("[TB] FAIL saturated_yield: sel=%b data=%h, want 1 00000022", select, out_data);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h5555_5555, 1'b1);
    tick();
    checks++;
    if (out_data !== 32'h5555_5555 || select !== 1'b1 || {ack_1, ack_0} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL bp_grant: data=%h sel=%b acks=%b, want 55555555 1 10",
               out_data, select, {ack_1, ack_0});
    end
    applyStimulus(1'b1, 32'hCAFE_0000, 1'b0, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h5555_5555 || select !== 1'b1 ||
          {ack_1, ack_0} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: valid=%b data=%h sel=%b acks=%b, want 1 55555555 1 00",
                 i, out_valid, out_data, select, {ack_1, ack_0});
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hCAFE_0000 || select !== 1'b0 ||
        {ack_1, ack_0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_release: valid=%b data=%h sel=%b acks=%b, want 1 cafe0000 0 01",
               out_valid, out_data, select, {ack_1, ack_0});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h7777_7777, 1'b0);
    tick();
    req_1 = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || select !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_hold: valid=%b sel=%b, want 1 1", out_valid, select);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, select, ack_1, ack_0} !== 4'b0000 || out_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: valid=%b sel=%b acks=%b data=%h, want 0 0 00 00000000",
               out_valid, select, {ack_1, ack_0}, out_data);
    end
    applyStimulus(1'b1, 32'h0000_00A0, 1'b1, 32'h0000_00B0, 1'b1);
    tick();
    checks++;
    if (select !== 1'b0 || out_data !== 32'h0000_00A0) begin
      errors++;
      $display("[TB] FAIL mid_after: sel=%b data=%h, want 0 000000a0", select, out_data);
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_0011, 1'b1);
    tick();
    data_1 = 32'h0000_0022;
    tick();
    checks++;
    if (select !== 1'b1 || out_data !== 32'h0000_0022) begin
      errors++;
      $display("[TB] FAIL drop_owner: sel=%b data=%h, want 1 00000022", select, out_data);
    end
    applyStimulus(1'b1, 32'h0000_0033, 1'b0, 32'h0, 1'b1);
    tick();
    checks++;
    if (out_valid !== 1'b1 || select !== 1'b0 || out_data !== 32'h0000_0033 ||
        {ack_1, ack_0} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL drop_switch: valid=%b sel=%b data=%h acks=%b, want 1 0 00000033 01",
               out_valid, select, out_data, {ack_1, ack_0});
    end
    // burst count is now 1, so requester 0 stays sticky against a new competitor
    applyStimulus(1'b1, 32'h0000_0044, 1'b1, 32'h0000_0055, 1'b1);
    tick();
    checks++;
    if (select !== 1'b0 || out_data !== 32'h0000_0044) begin
      errors++;
      $display("[TB] FAIL drop_sticky: sel=%b data=%h, want 0 00000044", select, out_data);
    end
  endtask

  task automatic test_idle_reset();
    do_reset();
    applyStimulus(1'b1, 32'h0000_0066, 1'b0, 32'h0000_0077, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_valid: valid=%b, want 0", out_valid);
    end
    applyStimulus(1'b1, 32'h0000_0066, 1'b1, 32'h0000_0077, 1'b1);
    tick();
    checks++;
    if (select !== 1'b1 || out_data !== 32'h0000_0077) begin
      errors++;
      $display("[TB] FAIL idle_cnt_clear: sel=%b data=%h, want 1 00000077", select, out_data);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    test_reset();
    test_single();
    test_simultaneous();
    test_burst_cap();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_owner_drop();
    test_idle_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
